// File: rtl/virtual_ds2431_rom_dispatcher.sv
// virtual_ds2431_rom_dispatcher
// ROM-layer sequencer for the virtual DS2431. After every bus reset it reads the
// ROM command byte, then either runs a ROM sub-block (Read/Match/Search) or handles
// Skip/Resume itself, and finally hands the byte transceiver to the function layer.
// It owns the single transceiver and muxes it to whichever layer currently runs.
module virtual_ds2431_rom_dispatcher #(
    parameter logic [7:0] CMD_READ   = 8'h33,
    parameter logic [7:0] CMD_MATCH  = 8'h55,
    parameter logic [7:0] CMD_SEARCH = 8'hF0,
    parameter logic [7:0] CMD_SKIP   = 8'hCC,
    parameter logic [7:0] CMD_RESUME = 8'hA5,
    parameter int         WDOG_W     = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        busReset_i,
    input  logic [7:0]  rxDat_i,
    input  logic        transDone_i,
    output logic [7:0]  txDat_o,
    output logic        transTrig_o,
    output logic        nRxTx_o,
    output logic [2:0]  sub_run_o,
    input  logic [23:0] sub_txDat_i,
    input  logic [2:0]  sub_trig_i,
    input  logic [2:0]  sub_nRxTx_i,
    input  logic [2:0]  sub_done_i,
    input  logic [2:0]  sub_pass_i,
    output logic        func_run_o,
    input  logic [7:0]  func_txDat_i,
    input  logic        func_trig_i,
    input  logic        func_nRxTx_i,
    input  logic        func_done_i,
    output logic        rcFlag_o,
    output logic        stalled_o,
    output logic [7:0]  romCmd_o
);

    localparam int NSUB = 3;
    // Watchdog fires on the edge that ends the (2**WDOG_W-1)-th cycle in a phase.
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE, GET_CMD, WAIT_CMD, DECODE, SUB, FUNC, STALL
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           subIdx_q, subIdx_d;
    logic                 rcFlag_q, rcFlag_d;
    logic [7:0]           romCmd_q, romCmd_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [NSUB-1:0]      subRun_q, subRun_d;
    logic                 funcRun_q, funcRun_d;
    logic                 transDone_q;
    logic [NSUB-1:0]      subDone_q;
    logic                 funcDone_q;

    logic                 transEdge;
    logic [NSUB-1:0]      subEdge;
    logic                 funcEdge;
    logic                 wdogHit;
    logic                 wdogPhase;
    logic [NSUB-1:0][7:0] subTx;

    assign transEdge = transDone_i & ~transDone_q;
    assign subEdge   = sub_done_i & ~subDone_q;
    assign funcEdge  = func_done_i & ~funcDone_q;
    assign subTx     = sub_txDat_i;
    assign wdogPhase = (state_q == WAIT_CMD) || (state_q == SUB) || (state_q == FUNC);
    assign wdogHit   = wdogPhase && (wdog_q == WDOG_LAST);

    // Next-state logic: phase sequencing, opcode decode, done handling, watchdog.
    always_comb begin
        state_d  = state_q;
        subIdx_d = subIdx_q;
        rcFlag_d = rcFlag_q;
        romCmd_d = romCmd_q;
        case (state_q)
            IDLE: ;
            GET_CMD: state_d = WAIT_CMD;
            WAIT_CMD: begin
                if (transEdge) begin
                    romCmd_d = rxDat_i;
                    state_d  = DECODE;
                end else if (wdogHit) begin
                    state_d = STALL;
                end
            end
            DECODE: begin
                case (romCmd_q)
                    CMD_READ:   begin subIdx_d = 2'd0; state_d = SUB; end
                    CMD_MATCH:  begin subIdx_d = 2'd1; state_d = SUB; end
                    CMD_SEARCH: begin subIdx_d = 2'd2; state_d = SUB; end
                    CMD_SKIP:   begin rcFlag_d = 1'b0; state_d = FUNC; end
                    CMD_RESUME: state_d = rcFlag_q ? FUNC : STALL;
                    default:    state_d = STALL;
                endcase
            end
            SUB: begin
                if (subEdge[subIdx_q]) begin
                    if (subIdx_q == 2'd0) begin
                        // Read ROM always selects the device.
                        rcFlag_d = 1'b0;
                        state_d  = FUNC;
                    end else begin
                        rcFlag_d = sub_pass_i[subIdx_q];
                        state_d  = sub_pass_i[subIdx_q] ? FUNC : STALL;
                    end
                end else if (wdogHit) begin
                    state_d = STALL;
                end
            end
            FUNC: begin
                if (funcEdge || wdogHit) state_d = STALL;
            end
            STALL: ;
            default: state_d = IDLE;
        endcase
        // A bus reset restarts the ROM layer from any state; rcFlag survives it.
        if (busReset_i) state_d = GET_CMD;
    end

    // Run levels follow the next state so they drop on the same edge the phase ends.
    always_comb begin
        subRun_d  = (state_d == SUB) ? (3'b001 << subIdx_d) : 3'b000;
        funcRun_d = (state_d == FUNC);
        wdog_d    = (wdogPhase && state_d == state_q) ? wdog_q + 1'b1 : '0;
    end

    // Transceiver mux: current owner drives, otherwise the bus idles.
    always_comb begin
        txDat_o     = 8'hFF;
        transTrig_o = 1'b0;
        nRxTx_o     = 1'b0;
        case (state_q)
            GET_CMD: transTrig_o = 1'b1;
            SUB: begin
                txDat_o     = subTx[subIdx_q];
                transTrig_o = sub_trig_i[subIdx_q];
                nRxTx_o     = sub_nRxTx_i[subIdx_q];
            end
            FUNC: begin
                txDat_o     = func_txDat_i;
                transTrig_o = func_trig_i;
                nRxTx_o     = func_nRxTx_i;
            end
            default: ;
        endcase
    end

    // State and history registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            subIdx_q    <= 2'd0;
            rcFlag_q    <= 1'b0;
            romCmd_q    <= 8'h00;
            wdog_q      <= '0;
            subRun_q    <= '0;
            funcRun_q   <= 1'b0;
            transDone_q <= 1'b0;
            subDone_q   <= '0;
            funcDone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            subIdx_q    <= subIdx_d;
            rcFlag_q    <= rcFlag_d;
            romCmd_q    <= romCmd_d;
            wdog_q      <= wdog_d;
            subRun_q    <= subRun_d;
            funcRun_q   <= funcRun_d;
            transDone_q <= transDone_i;
            subDone_q   <= sub_done_i;
            funcDone_q  <= func_done_i;
        end
    end

    assign sub_run_o  = subRun_q;
    assign func_run_o = funcRun_q;
    assign rcFlag_o   = rcFlag_q;
    assign stalled_o  = (state_q == STALL);
    assign romCmd_o   = romCmd_q;

endmodule

// File: tb/tb_virtual_ds2431_rom_dispatcher.sv
// Bench for virtual_ds2431_rom_dispatcher: directed sessions from the block's
// scenarios, then randomized ROM sessions against an outcome-level reference model.
module tb_virtual_ds2431_rom_dispatcher;

    localparam int WDOG_W = 4;
    localparam int WDOG_LIMIT = (1 << WDOG_W) - 1;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        busReset = 1'b0;
    logic [7:0]  rxDat = 8'h00;
    logic        transDone = 1'b0;
    logic [7:0]  txDat;
    logic        transTrig;
    logic        nRxTx;
    logic [2:0]  sub_run;
    logic [23:0] sub_txDat = '0;
    logic [2:0]  sub_trig = '0;
    logic [2:0]  sub_nRxTx = '0;
    logic [2:0]  sub_done = '0;
    logic [2:0]  sub_pass = '0;
    logic        func_run;
    logic [7:0]  func_txDat = 8'h00;
    logic        func_trig = 1'b0;
    logic        func_nRxTx = 1'b0;
    logic        func_done = 1'b0;
    logic        rcFlag;
    logic        stalled;
    logic [7:0]  romCmd;

    int total = 0;
    int bad = 0;
    bit rc_m = 1'b0;

    always #5 clk = ~clk;

    virtual_ds2431_rom_dispatcher #(.WDOG_W(WDOG_W)) dut (
        .clk(clk), .nRst(nRst), .busReset_i(busReset), .rxDat_i(rxDat),
        .transDone_i(transDone), .txDat_o(txDat), .transTrig_o(transTrig),
        .nRxTx_o(nRxTx), .sub_run_o(sub_run), .sub_txDat_i(sub_txDat),
        .sub_trig_i(sub_trig), .sub_nRxTx_i(sub_nRxTx), .sub_done_i(sub_done),
        .sub_pass_i(sub_pass), .func_run_o(func_run), .func_txDat_i(func_txDat),
        .func_trig_i(func_trig), .func_nRxTx_i(func_nRxTx), .func_done_i(func_done),
        .rcFlag_o(rcFlag), .stalled_o(stalled), .romCmd_o(romCmd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_reset();
        busReset = 1'b1;
        tick();
        busReset = 1'b0;
        #1;
    endtask

    // Outcome of one ROM session from the opcode table: which sub-block runs
    // (-1 = none), whether the function layer gets the bus, and the new rcFlag.
    function automatic void predict(input logic [7:0] op, input bit pass, input bit rc_in,
                                    output int sub, output bit to_func, output bit rc_out);
        sub = -1; to_func = 1'b0; rc_out = rc_in;
        case (op)
            8'h33: begin sub = 0; to_func = 1'b1; rc_out = 1'b0; end
            8'h55: begin sub = 1; to_func = pass; rc_out = pass; end
            8'hF0: begin sub = 2; to_func = pass; rc_out = pass; end
            8'hCC: begin to_func = 1'b1; rc_out = 1'b0; end
            8'hA5: begin to_func = rc_in; rc_out = rc_in; end
            default: ;
        endcase
    endfunction

    task automatic send_cmd(input logic [7:0] op, input int d1);
        tick();
        chk("wait_trig", transTrig, 0);
        repeat (d1) tick();
        rxDat = op;
        transDone = 1'b1;
        tick();
        transDone = 1'b0;
        rxDat = 8'($urandom);
        #1;
        chk("romCmd", romCmd, op);
    endtask

    task automatic session(input logic [7:0] op, input bit pass, input int d1, input int d2);
        int sub;
        bit to_func, new_rc;
        predict(op, pass, rc_m, sub, to_func, new_rc);
        bus_reset();
        chk("get_trig", transTrig, 1);
        chk("get_dir", nRxTx, 0);
        chk("get_subrun", sub_run, 0);
        chk("get_funcrun", func_run, 0);
        chk("get_stalled", stalled, 0);
        chk("get_rc", rcFlag, rc_m);
        send_cmd(op, d1);
        tick();
        #1;
        if (sub >= 0) begin
            chk("sub_run", sub_run, 32'(3'b001 << sub));
            chk("sub_funcrun", func_run, 0);
            chk("sub_stalled", stalled, 0);
            sub_txDat = 24'($urandom); sub_trig = 3'($urandom); sub_nRxTx = 3'($urandom);
            func_trig = 1'b1; func_txDat = 8'($urandom); func_nRxTx = 1'b1;
            #1;
            chk("sub_txDat", txDat, sub_txDat[8*sub +: 8]);
            chk("sub_trig", transTrig, sub_trig[sub]);
            chk("sub_dir", nRxTx, sub_nRxTx[sub]);
            tick();
            sub_trig = '0; func_trig = 1'b0; func_nRxTx = 1'b0;
            sub_done = 3'b111 & ~(3'b001 << sub);
            func_done = 1'b1;
            tick();
            sub_done = '0; func_done = 1'b0;
            #1;
            chk("nonowner_done", sub_run, 32'(3'b001 << sub));
            repeat (d2) tick();
            sub_pass = 3'($urandom);
            sub_pass[sub] = pass;
            sub_done[sub] = 1'b1;
            tick();
            sub_done = '0;
            #1;
            chk("subdone_run", sub_run, 0);
        end else begin
            chk("nosub_run", sub_run, 0);
        end
        chk("out_funcrun", func_run, to_func);
        chk("out_stalled", stalled, !to_func);
        chk("out_rc", rcFlag, new_rc);
        rc_m = new_rc;
        if (to_func) begin
            func_txDat = 8'($urandom); func_trig = 1'($urandom); func_nRxTx = 1'($urandom);
            sub_trig = 3'b111;
            #1;
            chk("func_txDat", txDat, func_txDat);
            chk("func_trig", transTrig, func_trig);
            chk("func_dir", nRxTx, func_nRxTx);
            tick();
            func_trig = 1'b0; sub_trig = '0;
            func_done = 1'b1;
            tick();
            func_done = 1'b0;
            #1;
            chk("funcdone_run", func_run, 0);
            chk("funcdone_stalled", stalled, 1);
        end
        sub_trig = 3'b111; func_trig = 1'b1; sub_nRxTx = 3'b111; func_nRxTx = 1'b1;
        sub_txDat = 24'($urandom); func_txDat = 8'($urandom);
        #1;
        chk("stall_trig", transTrig, 0);
        chk("stall_txDat", txDat, 8'hFF);
        chk("stall_dir", nRxTx, 0);
        tick();
        sub_trig = '0; func_trig = 1'b0; sub_nRxTx = '0; func_nRxTx = 1'b0;
    endtask

    initial begin
        logic [7:0] ops [5];
        logic [7:0] op;
        ops[0] = 8'h33; ops[1] = 8'h55; ops[2] = 8'hF0; ops[3] = 8'hCC; ops[4] = 8'hA5;

        // Reset values
        #12;
        chk("rst_txDat", txDat, 8'hFF);
        chk("rst_trig", transTrig, 0);
        chk("rst_dir", nRxTx, 0);
        chk("rst_subrun", sub_run, 0);
        chk("rst_funcrun", func_run, 0);
        chk("rst_rc", rcFlag, 0);
        chk("rst_stalled", stalled, 0);
        chk("rst_romCmd", romCmd, 8'h00);
        nRst = 1'b1;
        tick();
        sub_trig = 3'b111; func_trig = 1'b1;
        #1;
        chk("idle_trig", transTrig, 0);
        sub_trig = '0; func_trig = 1'b0;
        tick();

        // Directed ROM sessions
        session(8'h33, 1'b0, 0, 0);
        session(8'h55, 1'b1, 2, 1);
        session(8'hA5, 1'b0, 1, 0);
        session(8'hF0, 1'b0, 3, 2);
        session(8'hA5, 1'b0, 0, 0);
        session(8'h3C, 1'b0, 1, 0);
        session(8'hCC, 1'b0, 0, 0);

        // Bus reset in the middle of Match ROM
        bus_reset();
        send_cmd(8'h55, 1);
        tick();
        #1;
        chk("mid_subrun", sub_run, 3'b010);
        busReset = 1'b1;
        tick();
        busReset = 1'b0;
        #1;
        chk("mid_rst_subrun", sub_run, 0);
        chk("mid_rst_trig", transTrig, 1);
        chk("mid_rst_dir", nRxTx, 0);
        chk("mid_rst_rc", rcFlag, rc_m);
        tick();

        // Watchdog: sub-block never finishes
        bus_reset();
        send_cmd(8'h33, 0);
        tick();
        for (int c = 1; c <= WDOG_LIMIT + 1; c++) begin
            #1;
            chk("wdog_subrun", sub_run, (c <= WDOG_LIMIT) ? 32'd1 : 32'd0);
            chk("wdog_stalled", stalled, (c > WDOG_LIMIT) ? 32'd1 : 32'd0);
            tick();
        end

        // Asynchronous reset mid-operation clears rcFlag
        session(8'h55, 1'b1, 0, 0);
        bus_reset();
        tick();
        #3;
        nRst = 1'b0;
        #1;
        chk("arst_rc", rcFlag, 0);
        chk("arst_romCmd", romCmd, 8'h00);
        chk("arst_trig", transTrig, 0);
        chk("arst_stalled", stalled, 0);
        rc_m = 1'b0;
        tick();
        nRst = 1'b1;
        tick();

        // Randomized sessions
        for (int n = 0; n < 30; n++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            if (sel < 5) begin
                op = ops[sel];
            end else begin
                op = 8'($urandom);
                while (op == 8'h33 || op == 8'h55 || op == 8'hF0 || op == 8'hCC || op == 8'hA5)
                    op = 8'($urandom);
            end
            session(op, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
